// File: rtl/filter_ctrl_5x5.sv
// Sequencer for the 5x5 filter line-buffer path: tracks frame/line/pixel position,
// drives line-memory strobes and aligner selects, and delays sync to the pipeline output.
module filter_ctrl_5x5 #(
  parameter int ADDR_WIDTH = 12,
  parameter int MAX_WIDTH  = 1920,
  parameter int PIPE_LAT   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_bypass,
  input  logic                  i_vs,
  input  logic                  i_hs,
  input  logic                  i_de,
  output logic [3:0]            o_mem_wen,
  output logic                  o_mem_ren,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [3:0]            o_conv_wen,
  output logic                  o_conv_ren,
  output logic [2:0]            o_conv_ln_sel,
  output logic [2:0]            o_conv_px_sel,
  output logic                  o_vs,
  output logic                  o_hs,
  output logic                  o_de,
  output logic                  o_ovf
);

  typedef enum logic [1:0] {IDLE, FILL, ACTIVE} state_t;

  localparam logic [ADDR_WIDTH-1:0] MAX_COL  = ADDR_WIDTH'(MAX_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_COL = ADDR_WIDTH'(MAX_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] FOUR_COL = ADDR_WIDTH'(4);

  state_t                  state_q, state_d;
  logic [2:0]              line_cnt_q, line_cnt_d;
  logic [ADDR_WIDTH-1:0]   col_q, col_d, col_eff;
  logic [1:0]              wr_ptr_q, wr_ptr_d;
  logic                    ovf_q, ovf_d;
  logic                    skip_q, skip_d;
  logic                    vs_prev_q, de_prev_q;
  logic [3:0]              mem_wen_q, mem_wen_d;
  logic                    mem_ren_q, mem_ren_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic                    conv_en_q, conv_en_d;
  logic [2:0]              ln_sel_q, ln_sel_d;
  logic [2:0]              px_sel_q, px_sel_d;
  logic [PIPE_LAT:0][2:0]  sync_q, sync_d;
  logic                    vs_rise, de_fall, pix;

  always_comb begin
    state_d    = state_q;
    line_cnt_d = line_cnt_q;
    wr_ptr_d   = wr_ptr_q;
    skip_d     = skip_q;
    vs_rise    = i_vs & ~vs_prev_q;
    de_fall    = de_prev_q & ~i_de;
    col_eff    = vs_rise ? '0 : col_q;
    // skip_q marks the tail of a line that was cut by a frame start; it is not a line
    pix        = i_de && (state_q != IDLE) && !skip_q && !vs_rise;

    mem_wen_d  = (pix && col_q < MAX_COL) ? (4'b0001 << wr_ptr_q) : '0;
    mem_ren_d  = pix && col_q < MAX_COL;
    mem_addr_d = (col_eff >= MAX_COL) ? LAST_COL : col_eff;
    px_sel_d   = (col_eff >= FOUR_COL) ? 3'd4 : col_eff[2:0];
    conv_en_d  = (state_q == ACTIVE) && i_de && (col_q >= FOUR_COL) && !i_bypass && !vs_rise;
    ovf_d      = ovf_q | (pix && col_q >= MAX_COL);

    if (i_de) col_d = (col_q >= MAX_COL) ? col_q : col_q + 1'b1;
    else      col_d = '0;

    if (de_fall) begin
      skip_d = 1'b0;
      if (state_q != IDLE && !skip_q) begin
        if (line_cnt_q != 3'd4) line_cnt_d = line_cnt_q + 3'd1;
        wr_ptr_d = wr_ptr_q + 2'd1;
        if (state_q == FILL && line_cnt_d == 3'd4) state_d = ACTIVE;
      end
    end

    if (vs_rise) begin
      state_d    = FILL;
      line_cnt_d = '0;
      col_d      = '0;
      wr_ptr_d   = '0;
      ovf_d      = 1'b0;
      skip_d     = i_de;
    end

    ln_sel_d = (state_d == ACTIVE) ? {1'b0, wr_ptr_d} : 3'd4;
    sync_d   = {sync_q[PIPE_LAT-1:0], {i_vs, i_hs, i_de}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      line_cnt_q <= '0;
      col_q      <= '0;
      wr_ptr_q   <= '0;
      ovf_q      <= 1'b0;
      skip_q     <= 1'b0;
      vs_prev_q  <= 1'b0;
      de_prev_q  <= 1'b0;
      mem_wen_q  <= '0;
      mem_ren_q  <= 1'b0;
      mem_addr_q <= '0;
      conv_en_q  <= 1'b0;
      ln_sel_q   <= 3'd4;
      px_sel_q   <= '0;
      sync_q     <= '0;
    end else begin
      state_q    <= state_d;
      line_cnt_q <= line_cnt_d;
      col_q      <= col_d;
      wr_ptr_q   <= wr_ptr_d;
      ovf_q      <= ovf_d;
      skip_q     <= skip_d;
      vs_prev_q  <= i_vs;
      de_prev_q  <= i_de;
      mem_wen_q  <= mem_wen_d;
      mem_ren_q  <= mem_ren_d;
      mem_addr_q <= mem_addr_d;
      conv_en_q  <= conv_en_d;
      ln_sel_q   <= ln_sel_d;
      px_sel_q   <= px_sel_d;
      sync_q     <= sync_d;
    end
  end

  assign o_mem_wen     = mem_wen_q;
  assign o_mem_ren     = mem_ren_q;
  assign o_mem_addr    = mem_addr_q;
  assign o_conv_wen    = mem_wen_q;
  assign o_conv_ren    = conv_en_q;
  assign o_conv_ln_sel = ln_sel_q;
  assign o_conv_px_sel = px_sel_q;
  assign o_ovf         = ovf_q;
  assign o_vs          = sync_q[PIPE_LAT][2];
  assign o_hs          = sync_q[PIPE_LAT][1];
  assign o_de          = sync_q[PIPE_LAT][0];

endmodule

// File: tb/tb_filter_ctrl_5x5.sv
// Scoreboard bench for filter_ctrl_5x5: randomized frames against a cycle-level reference model.
module tb_filter_ctrl_5x5;
  localparam int AW = 12;
  localparam int MW = 12;
  localparam int PL = 4;

  logic clk = 1'b0, rst = 1'b1;
  logic i_bypass = 1'b0, i_vs = 1'b0, i_hs = 1'b0, i_de = 1'b0;
  logic [3:0] o_mem_wen, o_conv_wen;
  logic o_mem_ren, o_conv_ren, o_vs, o_hs, o_de, o_ovf;
  logic [AW-1:0] o_mem_addr;
  logic [2:0] o_conv_ln_sel, o_conv_px_sel;

  filter_ctrl_5x5 #(.ADDR_WIDTH(AW), .MAX_WIDTH(MW), .PIPE_LAT(PL)) dut (
    .clk(clk), .rst(rst), .i_bypass(i_bypass), .i_vs(i_vs), .i_hs(i_hs), .i_de(i_de),
    .o_mem_wen(o_mem_wen), .o_mem_ren(o_mem_ren), .o_mem_addr(o_mem_addr),
    .o_conv_wen(o_conv_wen), .o_conv_ren(o_conv_ren), .o_conv_ln_sel(o_conv_ln_sel),
    .o_conv_px_sel(o_conv_px_sel), .o_vs(o_vs), .o_hs(o_hs), .o_de(o_de), .o_ovf(o_ovf));

  always #5 clk = ~clk;

  typedef struct {
    int cyc; int wen; int ren; int addr; int conv; int lnsel; int px; int ovf;
  } exp_t;
  typedef struct { int cyc; int vs; int hs; int de; } sync_t;

  exp_t  exp_q[$];
  sync_t sync_q[$];
  int cyc = 0;
  int checks = 0, failures = 0;

  // reference model state: frame progress in terms of lines and columns
  int m_started = 0, m_active = 0, m_lines = 0, m_ptr = 0, m_col = 0;
  int m_skip = 0, m_ovf = 0, m_pvs = 0, m_pde = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, req);
    end
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("mem_wen", int'(o_mem_wen), e.wen);
      chk("conv_wen", int'(o_conv_wen), e.wen);
      chk("mem_ren", int'(o_mem_ren), e.ren);
      chk("mem_addr", int'(o_mem_addr), e.addr);
      chk("conv_ren", int'(o_conv_ren), e.conv);
      chk("ln_sel", int'(o_conv_ln_sel), e.lnsel);
      chk("px_sel", int'(o_conv_px_sel), e.px);
      chk("ovf", int'(o_ovf), e.ovf);
    end
    while (sync_q.size() > 0 && sync_q[0].cyc <= cyc) begin
      sync_t s;
      s = sync_q.pop_front();
      chk("o_vs", int'(o_vs), s.vs);
      chk("o_hs", int'(o_hs), s.hs);
      chk("o_de", int'(o_de), s.de);
    end
  end

  task automatic step(input int vs, input int hs, input int de, input int byp);
    exp_t e;
    sync_t s;
    int vsr, framed, pix;
    @(posedge clk);
    #1;
    i_vs = vs[0]; i_hs = hs[0]; i_de = de[0]; i_bypass = byp[0];
    vsr    = (vs != 0 && m_pvs == 0) ? 1 : 0;
    framed = (m_started != 0 && m_skip == 0) ? 1 : 0;
    pix    = (de != 0 && framed != 0 && vsr == 0) ? 1 : 0;
    e.cyc  = cyc + 1;
    e.wen  = (pix != 0 && m_col < MW) ? (1 << m_ptr) : 0;
    e.ren  = (pix != 0 && m_col < MW) ? 1 : 0;
    e.conv = (vsr == 0 && m_active != 0 && de != 0 && m_col >= 4 && byp == 0) ? 1 : 0;
    if (pix != 0 && m_col >= MW) m_ovf = 1;
    if (vsr != 0) begin
      e.addr = 0; e.px = 0;
      m_started = 1; m_active = 0; m_lines = 0; m_ptr = 0; m_col = 0; m_ovf = 0;
      m_skip = de;
    end else begin
      e.addr = (m_col >= MW) ? MW - 1 : m_col;
      e.px   = (m_col > 4) ? 4 : m_col;
      if (m_pde != 0 && de == 0) begin
        if (framed != 0) begin
          if (m_lines < 4) m_lines++;
          m_ptr = (m_ptr + 1) % 4;
          if (m_lines == 4) m_active = 1;
        end
        m_skip = 0;
      end
      m_col = (de != 0) ? ((m_col + 1 > MW) ? MW : m_col + 1) : 0;
    end
    e.lnsel = (m_active != 0) ? m_ptr : 4;
    e.ovf   = m_ovf;
    m_pvs = vs; m_pde = de;
    exp_q.push_back(e);
    s.cyc = cyc + 1 + PL; s.vs = vs; s.hs = hs; s.de = de;
    sync_q.push_back(s);
  endtask

  task automatic hblank(input int byp);
    step(0, 1, 0, byp);
    step(0, 1, 0, byp);
    repeat ($urandom_range(1, 3)) step(0, 0, 0, byp);
  endtask

  initial begin
    int nlines, w, byp, vs, budget;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_wen", int'(o_mem_wen), 0);
    chk("rst_ln_sel", int'(o_conv_ln_sel), 4);
    chk("rst_ovf", int'(o_ovf), 0);
    chk("rst_o_de", int'(o_de), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // pixels with no preceding frame start must not write
    for (int l = 0; l < 3; l++) begin
      for (int p = 0; p < 5; p++) step(0, 0, 1, 0);
      hblank(0);
    end

    for (int f = 0; f < 6; f++) begin
      byp = (f == 2) ? 1 : ((f > 3) ? int'($urandom_range(0, 1)) : 0);
      step(1, 0, 0, byp);
      step(1, 0, 0, byp);
      repeat (3) step(0, 0, 0, byp);
      nlines = (f == 0) ? 6 : int'($urandom_range(5, 7));
      for (int l = 0; l < nlines; l++) begin
        w = (f == 0) ? 10 : int'($urandom_range(6, 15));
        for (int p = 0; p < w; p++) begin
          // frame 4 restarts during its third line while pixels are flowing
          vs = (f == 4 && l == 2 && p >= 3) ? 1 : 0;
          step(vs, 0, 1, byp);
        end
        hblank(byp);
      end
    end
    repeat (PL + 3) step(0, 0, 0, 0);

    budget = 50;
    while ((exp_q.size() > 0 || sync_q.size() > 0) && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    @(negedge clk);
    chk("drain_exp", exp_q.size(), 0);
    chk("drain_sync", sync_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
